// File: rtl/sram_resp_pkg.sv
// Shared widths and lane helpers for the sram_resp memory responder.
// Optional parity storage is enabled by defining SRAM_RESP_PARITY_EN (off by default).
package sram_resp_pkg;

  localparam int SRAM_RESP_DATA_W = 32;
  localparam int SRAM_RESP_LANES  = 4;
  localparam int SRAM_RESP_CNT_W  = 16;

  typedef logic [SRAM_RESP_DATA_W-1:0] word_t;
  typedef logic [SRAM_RESP_LANES-1:0]  lane_t;

  // Write-first merge: enabled lanes take the new byte, others keep the old one.
  function automatic word_t lane_merge(input word_t old_w, input word_t new_w, input lane_t be);
    word_t m;
    for (int b = 0; b < SRAM_RESP_LANES; b++)
      m[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return m;
  endfunction

  function automatic lane_t byte_parity(input word_t w);
    lane_t p;
    for (int b = 0; b < SRAM_RESP_LANES; b++)
      p[b] = ^w[8*b +: 8];
    return p;
  endfunction

endpackage

// File: rtl/sram_resp_if.sv
// Instruction and data SRAM-like port bundle between the CPU core (master) and sram_resp (slave).
interface sram_resp_if;
  import sram_resp_pkg::*;

  logic  inst_sram_en;
  lane_t inst_sram_wen;
  word_t inst_sram_addr;
  word_t inst_sram_wdata;
  word_t inst_sram_rdata;

  logic  data_sram_en;
  lane_t data_sram_wen;
  word_t data_sram_addr;
  word_t data_sram_wdata;
  word_t data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  inst_sram_rdata, data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output inst_sram_rdata, data_sram_rdata
  );

endinterface

// File: rtl/sram_resp_array.sv
// Shared word storage: one byte-enabled write port, two asynchronous read ports.
// Per-byte parity bits are added when SRAM_RESP_PARITY_EN is defined. Contents are never reset.
module sram_resp_array
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  lane_t             i_wbe,
  input  word_t             i_wdata,
`ifdef SRAM_RESP_PARITY_EN
  input  lane_t             i_wpar,
  output lane_t             o_rpar0,
  output lane_t             o_rpar1,
`endif
  input  logic [ADDR_W-1:0] i_raddr0,
  input  logic [ADDR_W-1:0] i_raddr1,
  output word_t             o_rdata0,
  output word_t             o_rdata1
);

  localparam int DEPTH = 2 ** ADDR_W;

  word_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < SRAM_RESP_LANES; b++)
        if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

`ifdef SRAM_RESP_PARITY_EN
  lane_t r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < SRAM_RESP_LANES; b++)
        if (i_wbe[b]) r_par[i_waddr][b] <= i_wpar[b];
    end
  end

  assign o_rpar0 = r_par[i_raddr0];
  assign o_rpar1 = r_par[i_raddr1];
`endif

endmodule

// File: rtl/sram_resp.sv
// One-cycle SRAM responder for the core's instruction and data ports, with range/protocol error
// tracking. Define SRAM_RESP_PARITY_EN to add per-byte parity storage and checking.
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_resp_if.slave                 bus,
  input  logic                       err_clr,
  input  logic                       par_inject,
  output logic                       range_err,
  output logic                       inst_wr_err,
  output logic                       par_err,
  output logic [SRAM_RESP_CNT_W-1:0] err_cnt
);

  logic [ADDR_W-1:0] w_i_idx, w_d_idx;
  logic              w_i_inr, w_d_inr, w_d_rd, w_d_wr, w_we, w_coll;
  logic              w_i_perr, w_d_perr, w_i_ev, w_d_ev;
  word_t             w_i_word, w_d_word, w_i_val;
  word_t             r_inst_rdata, r_data_rdata;

  assign w_i_idx = bus.inst_sram_addr[ADDR_W+1:2];
  assign w_d_idx = bus.data_sram_addr[ADDR_W+1:2];
  assign w_i_inr = (bus.inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign w_d_inr = (bus.data_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign w_d_rd  = bus.data_sram_en && (bus.data_sram_wen == '0);
  assign w_d_wr  = bus.data_sram_en && (bus.data_sram_wen != '0);

  // A write sampled while rst is high must not reach the array.
  assign w_we   = w_d_wr && w_d_inr && !rst;
  assign w_coll = w_we && bus.inst_sram_en && w_i_inr && (w_i_idx == w_d_idx);
  assign w_i_val = w_coll ? lane_merge(w_i_word, bus.data_sram_wdata, bus.data_sram_wen) : w_i_word;

`ifdef SRAM_RESP_PARITY_EN
  lane_t w_wpar, w_i_par, w_d_par, w_i_par_mrg;
  logic  r_par_err;

  assign w_wpar      = byte_parity(bus.data_sram_wdata) ^ {SRAM_RESP_LANES{par_inject}};
  assign w_i_par_mrg = w_coll ? ((w_i_par & ~bus.data_sram_wen) | (w_wpar & bus.data_sram_wen))
                              : w_i_par;
  assign w_i_perr    = bus.inst_sram_en && w_i_inr && (byte_parity(w_i_val) != w_i_par_mrg);
  assign w_d_perr    = w_d_rd && w_d_inr && (byte_parity(w_d_word) != w_d_par);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par_err <= 1'b0;
    else     r_par_err <= (r_par_err && !err_clr) || w_i_perr || w_d_perr;
  end
  assign par_err = r_par_err;
`else
  assign w_i_perr = 1'b0;
  assign w_d_perr = 1'b0;
  assign par_err  = 1'b0;
`endif

  sram_resp_array #(.ADDR_W(ADDR_W)) u_array (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (w_d_idx),
    .i_wbe    (bus.data_sram_wen),
    .i_wdata  (bus.data_sram_wdata),
`ifdef SRAM_RESP_PARITY_EN
    .i_wpar   (w_wpar),
    .o_rpar0  (w_i_par),
    .o_rpar1  (w_d_par),
`endif
    .i_raddr0 (w_i_idx),
    .i_raddr1 (w_d_idx),
    .o_rdata0 (w_i_word),
    .o_rdata1 (w_d_word)
  );

  // Each port contributes at most one error event per cycle.
  assign w_i_ev = (bus.inst_sram_en && (!w_i_inr || (bus.inst_sram_wen != '0))) || w_i_perr;
  assign w_d_ev = (bus.data_sram_en && !w_d_inr) || w_d_perr;

  logic [1:0]                 w_inc;
  logic [SRAM_RESP_CNT_W-1:0] w_cnt_base, w_cnt_next;
  logic [SRAM_RESP_CNT_W:0]   w_sum;

  assign w_inc      = {1'b0, w_i_ev} + {1'b0, w_d_ev};
  assign w_cnt_base = err_clr ? '0 : err_cnt;
  assign w_sum      = {1'b0, w_cnt_base} + {{(SRAM_RESP_CNT_W-1){1'b0}}, w_inc};
  assign w_cnt_next = w_sum[SRAM_RESP_CNT_W] ? '1 : w_sum[SRAM_RESP_CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      range_err    <= 1'b0;
      inst_wr_err  <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (bus.inst_sram_en) r_inst_rdata <= w_i_inr ? w_i_val : '0;
      if (w_d_rd)           r_data_rdata <= w_d_inr ? w_d_word : '0;
      range_err   <= (range_err && !err_clr)
                     || (bus.inst_sram_en && !w_i_inr) || (bus.data_sram_en && !w_d_inr);
      inst_wr_err <= (inst_wr_err && !err_clr) || (bus.inst_sram_en && (bus.inst_sram_wen != '0));
      err_cnt     <= w_cnt_next;
    end
  end

  assign bus.inst_sram_rdata = r_inst_rdata;
  assign bus.data_sram_rdata = r_data_rdata;

  logic w_unused_ok;
`ifdef SRAM_RESP_PARITY_EN
  assign w_unused_ok = ^{bus.inst_sram_wdata, bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0]};
`else
  assign w_unused_ok = ^{bus.inst_sram_wdata, bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0],
                         par_inject};
`endif

endmodule

// File: tb/tb_sram_resp.sv
// Directed testbench for sram_resp: lane writes, write-first collision, range/protocol errors,
// err_clr priority, async reset with array retention, parity injection and counter saturation.
module tb_sram_resp;
  import sram_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        par_inject;
  logic        range_err, inst_wr_err, par_err;
  logic [15:0] err_cnt;

  int checkCount = 0;
  int passCount  = 0;

  sram_resp_if bus ();

  sram_resp #(.ADDR_W(12), .BASE(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_clr     (err_clr),
    .par_inject  (par_inject),
    .range_err   (range_err),
    .inst_wr_err (inst_wr_err),
    .par_err     (par_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    else
      passCount++;
  endtask

  // Drive one cycle of port activity, clock it, then settle just after the edge.
  task automatic applyStimulus(input logic iEn, input logic [3:0] iWen, input logic [31:0] iAddr,
                               input logic dEn, input logic [3:0] dWen, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic clr, input logic inj);
    bus.inst_sram_en    = iEn;
    bus.inst_sram_wen   = iWen;
    bus.inst_sram_addr  = iAddr;
    bus.inst_sram_wdata = 32'hFFFF_FFFF;
    bus.data_sram_en    = dEn;
    bus.data_sram_wen   = dWen;
    bus.data_sram_addr  = dAddr;
    bus.data_sram_wdata = dWdata;
    err_clr             = clr;
    par_inject          = inj;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_wen   = 4'h0;
    bus.inst_sram_addr  = 32'h0;
    bus.inst_sram_wdata = 32'hFFFF_FFFF;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    err_clr             = 1'b0;
    par_inject          = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("reset inst_rdata", bus.inst_sram_rdata, 32'h0);
    checkOutput("reset data_rdata", bus.data_sram_rdata, 32'h0);
    checkOutput("reset range_err", {31'h0, range_err}, 32'h0);
    checkOutput("reset inst_wr_err", {31'h0, inst_wr_err}, 32'h0);
    checkOutput("reset par_err", {31'h0, par_err}, 32'h0);
    checkOutput("reset err_cnt", {16'h0, err_cnt}, 32'h0);
    rst = 1'b0;

    // Full-word write, then read back; rdata must not change on the write cycle.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, 32'h10, 32'h1122_3344, 0, 0);
    checkOutput("write holds data_rdata", bus.data_sram_rdata, 32'h0);
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, 32'h10, 32'h0, 0, 0);
    checkOutput("read 0x10 full", bus.data_sram_rdata, 32'h1122_3344);
    idle();
    checkOutput("idle holds data_rdata", bus.data_sram_rdata, 32'h1122_3344);

    // Lanes 0 and 2 only.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'b0101, 32'h10, 32'hAABB_CCDD, 0, 0);
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, 32'h13, 32'h0, 0, 0);
    checkOutput("read 0x10 lanes", bus.data_sram_rdata, 32'h11BB_33DD);

    // Write-first collision, full word then a single lane.
    applyStimulus(1, 4'h0, 32'h20, 1, 4'hF, 32'h20, 32'hDEAD_BEEF, 0, 0);
    checkOutput("collision full", bus.inst_sram_rdata, 32'hDEAD_BEEF);
    checkOutput("collision data hold", bus.data_sram_rdata, 32'h11BB_33DD);
    applyStimulus(1, 4'h0, 32'h20, 1, 4'b1000, 32'h20, 32'h0100_0000, 0, 0);
    checkOutput("collision lane3", bus.inst_sram_rdata, 32'h01AD_BEEF);

    // Back-to-back instruction reads.
    applyStimulus(1, 4'h0, 32'h10, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    checkOutput("b2b inst 0x10", bus.inst_sram_rdata, 32'h11BB_33DD);
    applyStimulus(1, 4'h0, 32'h20, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    checkOutput("b2b inst 0x20", bus.inst_sram_rdata, 32'h01AD_BEEF);
    checkOutput("no errors yet", {16'h0, err_cnt}, 32'h0);

    // Both ports out of range in one cycle.
    applyStimulus(1, 4'h0, 32'h0000_4000, 1, 4'h0, 32'h8000_0000, 32'h0, 0, 0);
    checkOutput("oor inst_rdata", bus.inst_sram_rdata, 32'h0);
    checkOutput("oor data_rdata", bus.data_sram_rdata, 32'h0);
    checkOutput("oor range_err", {31'h0, range_err}, 32'h1);
    checkOutput("oor err_cnt", {16'h0, err_cnt}, 32'h2);
    checkOutput("oor inst_wr_err", {31'h0, inst_wr_err}, 32'h0);
    applyStimulus(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
    checkOutput("clr range_err", {31'h0, range_err}, 32'h0);
    checkOutput("clr err_cnt", {16'h0, err_cnt}, 32'h0);

    // Nonzero inst wen: flagged, read still performed.
    applyStimulus(1, 4'h1, 32'h10, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    checkOutput("inst wen read", bus.inst_sram_rdata, 32'h11BB_33DD);
    checkOutput("inst wen flag", {31'h0, inst_wr_err}, 32'h1);
    checkOutput("inst wen cnt", {16'h0, err_cnt}, 32'h1);

    // Error in the same cycle as err_clr wins; out-of-range write aliasing 0x10 is dropped.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, 32'h8000_0010, 32'h5555_5555, 1, 0);
    checkOutput("clr+err range_err", {31'h0, range_err}, 32'h1);
    checkOutput("clr+err inst_wr_err", {31'h0, inst_wr_err}, 32'h0);
    checkOutput("clr+err err_cnt", {16'h0, err_cnt}, 32'h1);
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, 32'h10, 32'h0, 0, 0);
    checkOutput("oor write dropped", bus.data_sram_rdata, 32'h11BB_33DD);

    // Async reset mid-stream; a write sampled under reset must not land.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, 32'h10, 32'h1122_3344, 0, 0);
    applyStimulus(1, 4'h0, 32'h10, 1, 4'h0, 32'h10, 32'h0, 0, 0);
    checkOutput("pre-reset data_rdata", bus.data_sram_rdata, 32'h1122_3344);
    bus.data_sram_wen   = 4'hF;
    bus.data_sram_wdata = 32'h9999_9999;
    rst = 1'b1;
    #1;
    checkOutput("async rst data_rdata", bus.data_sram_rdata, 32'h0);
    checkOutput("async rst inst_rdata", bus.inst_sram_rdata, 32'h0);
    checkOutput("async rst err_cnt", {16'h0, err_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, 32'h10, 32'h0, 0, 0);
    checkOutput("array retained", bus.data_sram_rdata, 32'h1122_3344);

    // Parity injection.
    applyStimulus(0, 4'h0, 32'h0, 1, 4'hF, 32'h30, 32'h1234_5678, 0, 1);
    applyStimulus(0, 4'h0, 32'h0, 1, 4'h0, 32'h30, 32'h0, 0, 0);
    checkOutput("parity read data", bus.data_sram_rdata, 32'h1234_5678);
`ifdef SRAM_RESP_PARITY_EN
    checkOutput("parity par_err", {31'h0, par_err}, 32'h1);
    checkOutput("parity err_cnt", {16'h0, err_cnt}, 32'h1);
`else
    checkOutput("parity par_err", {31'h0, par_err}, 32'h0);
    checkOutput("parity err_cnt", {16'h0, err_cnt}, 32'h0);
`endif

    // Saturation: two events per cycle up to and past 16'hFFFF.
    applyStimulus(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
    checkOutput("sat start", {16'h0, err_cnt}, 32'h0);
    for (int i = 0; i < 32767; i++)
      applyStimulus(1, 4'h0, 32'h0000_4000, 1, 4'h0, 32'h8000_0000, 32'h0, 0, 0);
    checkOutput("sat 65534", {16'h0, err_cnt}, 32'h0000_FFFE);
    applyStimulus(1, 4'h0, 32'h0000_4000, 1, 4'h0, 32'h8000_0000, 32'h0, 0, 0);
    checkOutput("sat clamp", {16'h0, err_cnt}, 32'h0000_FFFF);
    applyStimulus(1, 4'h0, 32'h0000_4000, 1, 4'h0, 32'h8000_0000, 32'h0, 0, 0);
    checkOutput("sat hold", {16'h0, err_cnt}, 32'h0000_FFFF);

    idle();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sram_resp.md
# sram_resp

Synchronous memory responder for the core's instruction and data SRAM-like ports; it is the target side of the interface the CPU core drives. It serves a read-only instruction port and a byte-writable data port from one shared word array. Read latency is one cycle, and there are no wait states. It sits in the SoC/testbench beside the core, replacing the vendor RAM, and adds out-of-range detection, error counters and an optional parity check.

## Interface
Parameters:
- ADDR_W, 12, word-address width; array depth is 2^ADDR_W words.
- BASE, 32'h0000_0000, region base; only bits [31:ADDR_W+2] are compared.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_sram_en  in  1  instruction access request.
- inst_sram_wen  in  4  must be 0; any nonzero value is a protocol error.
- inst_sram_addr  in  32  byte address; bits [1:0] are ignored.
- inst_sram_wdata  in  32  ignored.
- inst_sram_rdata  out  32  instruction word, registered.
- data_sram_en  in  1  data access request.
- data_sram_wen  in  4  byte-lane write enables; 0 means read.
- data_sram_addr  in  32  byte address; bits [1:0] are ignored.
- data_sram_wdata  in  32  write data; lane i is bits [8i+7:8i].
- data_sram_rdata  out  32  load data, registered.
- err_clr  in  1  synchronous clear of all sticky error state.
- par_inject  in  1  stores inverted parity for the current data write; this port only has an effect with the parity macro.
- range_err  out  1  sticky flag: an out-of-range access occurred.
- inst_wr_err  out  1  sticky flag: nonzero inst_sram_wen was seen together with inst_sram_en.
- par_err  out  1  sticky flag: parity mismatch on a read.
- err_cnt  out  16  saturating count of error events.

## Operation
Address decode:
- Word index is addr[ADDR_W+1:2].
- An address is in range when addr[31:ADDR_W+2] == BASE[31:ADDR_W+2].

Instruction port:
- When inst_sram_en=1 and the address is in range, the addressed word is registered into inst_sram_rdata.
- When inst_sram_en=1 and the address is out of range, inst_sram_rdata is loaded with 0 and range_err is set.
- Nonzero inst_sram_wen never writes the array; it sets inst_wr_err. The read is still performed.

Data port, read (en=1, wen=0):
- Behaves exactly like the instruction port.

Data port, write (en=1, wen≠0):
- Only the enabled byte lanes are written.
- data_sram_rdata holds its previous value.
- An out-of-range write is dropped and sets range_err.

Idle port (en=0):
- That port's rdata holds its previous value. It is never cleared by idleness.

Same-cycle collision:
- Condition: the data port writes word W while the instruction port reads W in the same cycle.
- Result: the instruction port returns the merged new word (write-first): new bytes on enabled lanes, old bytes elsewhere.

Error counting:
- Each port's error events (range or inst_wr) add 1 per port per cycle.
- When both ports err in the same cycle, err_cnt adds 2.
- err_cnt saturates at 16'hFFFF.

err_clr:
- Clears the three flags and err_cnt.
- If an error occurs in the same cycle as err_clr, the new error wins: its flag ends at 1 and err_cnt ends at the number of new events.

## Timing
- Request in cycle N produces rdata valid after the rising edge ending cycle N, i.e. usable in N+1. The core samples it in its MEM/ID stage.
- Back-to-back reads on every cycle are supported at full throughput.
- Reset values: inst_sram_rdata=0, data_sram_rdata=0, range_err=0, inst_wr_err=0, par_err=0, err_cnt=0.
- Array contents are not reset and are preserved across rst.
- Reset asserted mid-access:
  - outputs clear immediately (asynchronously);
  - the in-flight read result is discarded;
  - a write sampled on an edge while rst=1 is not performed.

## Configuration
- Macro: SRAM_RESP_PARITY_EN.
- When defined:
  - each byte stores one even-parity bit;
  - a write stores the parity of the written byte, or its inverse when par_inject=1;
  - every read, on either port and in range, checks the parity of all 4 bytes;
  - any mismatch sets par_err and adds 1 to err_cnt per port;
  - the returned data is unmodified.
- When undefined:
  - no parity storage is built;
  - par_inject is ignored;
  - par_err is a constant 0.

## Structure
- The shared defines header holds the SRAM_RESP_* widths (data width 32, byte lanes 4, err_cnt width 16) and the parity macro default.
- Sub-module sram_resp_array holds the storage:
  - one write port and two read ports;
  - byte enables;
  - the parity bits when configured.
- The top level owns decode, collision bypass, output registers and error logic.

## Test plan
- Write 32'h1122_3344 at data addr 0x10 with wen=4'hF, then read 0x10 with wen=0 -> data_sram_rdata=32'h1122_3344 one cycle later.
- From that state, write 32'hAABB_CCDD at 0x10 with wen=4'b0101, then read 0x10 -> 32'h11BB_33DD.
- In one cycle, data write 32'hDEAD_BEEF at 0x20 and instruction read 0x20 -> inst_sram_rdata=32'hDEAD_BEEF next cycle.
- Instruction read of BASE+(4<<ADDR_W) together with a data read at an out-of-range address -> both rdata=0, range_err=1, err_cnt=2. Then assert err_clr alone -> flag=0, cnt=0.
- Assert rst mid-stream after rdata=32'h1122_3344 -> rdata=0 immediately. Release rst and read 0x10 again -> 32'h1122_3344 (array retained).
- With SRAM_RESP_PARITY_EN: write 0x30 with par_inject=1, then read 0x30 -> data correct, par_err=1, err_cnt=1. Without the macro, the same sequence -> par_err=0, err_cnt=0.
